// File: rtl/hack_kbd_rx_if.sv
// Hack keyboard receiver bundle: serial line in, KBD word plus status out, CPU-side ack.
// Latency: none, wiring only. Backpressure: none; a word waits in the receiver until ack.
// master = receiver side, slave = CPU/memory-mux side that drives rx/ack and reads the word.
interface hack_kbd_rx_if;
    logic        rx;
    logic        ack;
    logic [15:0] out;
    logic        valid;
    logic        busy;
    logic        frame_err;
    logic        overrun;

    modport master (
        input  rx,
        input  ack,
        output out,
        output valid,
        output busy,
        output frame_err,
        output overrun
    );

    modport slave (
        output rx,
        output ack,
        input  out,
        input  valid,
        input  busy,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/hack_kbd_rx.sv
// Serial (start, 16 data LSB-first, [parity if HACK_KBD_RX_PARITY_EN], stop) receiver filling the Hack KBD word.
// Latency: commit SYNC_STAGES + CLKS_PER_BIT/2 + 17*CLKS_PER_BIT cycles after start edge (+CLKS_PER_BIT with parity).
// Backpressure: none; an unacked word is overwritten and flagged by sticky overrun, cleared by ack.
module hack_kbd_rx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic          clock,
    input  logic          reset,
    hack_kbd_rx_if.master kbd
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

`ifdef HACK_KBD_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic [3:0]             bitidx;
    logic [15:0]            shreg;
    logic [15:0]            out_q;
    logic                   valid_q;
    logic                   frame_err_q;
    logic                   overrun_q;
    logic                   rxs;
    logic                   frame_ok;
`ifdef HACK_KBD_RX_PARITY_EN
    logic                   par_q;
`endif

    assign rxs = sync_q[SYNC_STAGES-1];

`ifdef HACK_KBD_RX_PARITY_EN
    // Even parity over the 16 data bits plus the parity bit.
    assign frame_ok = rxs && ((^shreg ^ par_q) == 1'b0);
`else
    assign frame_ok = rxs;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q      <= '1;
            state       <= IDLE;
            cnt         <= '0;
            bitidx      <= '0;
            shreg       <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef HACK_KBD_RX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], kbd.rx};

            // ack first so a same-cycle commit or stop error below overrides it.
            if (kbd.ack) begin
                valid_q     <= 1'b0;
                overrun_q   <= 1'b0;
                frame_err_q <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rxs) begin
                            state  <= DATA;
                            bitidx <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == FULL_M1) begin
                        cnt    <= '0;
                        shreg  <= {rxs, shreg[15:1]};
                        bitidx <= bitidx + 4'd1;
                        if (bitidx == 4'd15) begin
`ifdef HACK_KBD_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef HACK_KBD_RX_PARITY_EN
                PARITY: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        par_q <= rxs;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (frame_ok) begin
                            out_q   <= shreg;
                            valid_q <= 1'b1;
                            if (valid_q && !kbd.ack) begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign kbd.out       = out_q;
    assign kbd.valid     = valid_q;
    assign kbd.frame_err = frame_err_q;
    assign kbd.overrun   = overrun_q;
    assign kbd.busy      = (state != IDLE);
endmodule

// File: tb/tb_hack_kbd_rx.sv
// Bench for hack_kbd_rx: directed frames from the test plan plus random frames, checked
// against a frame-level model of the KBD word and its status flags.
module tb_hack_kbd_rx;
    localparam int CPB  = 8;
    localparam int SYNC = 2;
`ifdef HACK_KBD_RX_PARITY_EN
    localparam int LAT = SYNC + CPB / 2 + 18 * CPB;
`else
    localparam int LAT = SYNC + CPB / 2 + 17 * CPB;
`endif

    logic clock = 1'b0;
    logic reset;

    hack_kbd_rx_if kif();

    hack_kbd_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .kbd   (kif.master)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_pass = 0;

    int   cyc = 0;
    int   start_cyc = 0;
    int   rise_cyc;
    logic prev_valid = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (kif.valid && !prev_valid) rise_cyc <= cyc;
        prev_valid <= kif.valid;
    end

    logic [15:0] m_out;
    logic        m_valid;
    logic        m_ovr;
    logic        m_ferr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".out"},       {16'd0, kif.out},       {16'd0, m_out});
        chk({tag, ".valid"},     {31'd0, kif.valid},     {31'd0, m_valid});
        chk({tag, ".frame_err"}, {31'd0, kif.frame_err}, {31'd0, m_ferr});
        chk({tag, ".overrun"},   {31'd0, kif.overrun},   {31'd0, m_ovr});
        chk({tag, ".busy"},      {31'd0, kif.busy},      32'd0);
    endtask

    // All drive tasks start and end 1 time unit after a rising edge.
    task automatic settle(input string tag);
        @(negedge clock);
        check_state(tag);
        @(posedge clock);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        kif.rx = b;
        repeat (CPB) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (kif.busy && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk("idle_timeout", {31'd0, kif.busy}, 32'd0);
        @(posedge clock);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] d, input logic stop, input logic par);
        logic good;
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 16; i++) drive_bit(d[i]);
`ifdef HACK_KBD_RX_PARITY_EN
        drive_bit(par);
        good = stop && ((^d ^ par) == 1'b0);
`else
        good = stop;
`endif
        drive_bit(stop);
        drive_bit(1'b1);
        drive_bit(1'b1);
        wait_idle();
        if (good) begin
            if (m_valid) m_ovr = 1'b1;
            m_out   = d;
            m_valid = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic do_ack();
        kif.ack = 1'b1;
        @(posedge clock);
        #1;
        kif.ack = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
    endtask

    function automatic logic even_par(input logic [15:0] d);
        return ^d;
    endfunction

    initial begin
        int          lat;
        logic [15:0] d;
        logic [15:0] aaaa;
        logic        stop;
        logic        par;

        reset   = 1'b1;
        kif.rx  = 1'b1;
        kif.ack = 1'b0;
        m_out   = 16'h0000;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (200) @(posedge clock);
        #1;
        settle("reset_idle");

        // 'A' with latency measured from the start edge to valid rising.
        send_frame(16'h0041, 1'b1, even_par(16'h0041));
        lat = rise_cyc - start_cyc - 1;
        chk("latency_window", {31'd0, (lat >= LAT - 1) && (lat <= LAT + 1)}, 32'd1);
        settle("frame_A");
        do_ack();
        settle("frame_A_ack");

        send_frame(16'h0080, 1'b1, even_par(16'h0080));
        send_frame(16'h0084, 1'b1, even_par(16'h0084));
        settle("overrun");
        do_ack();
        settle("overrun_ack");

        // Start pulse shorter than half a bit must be rejected.
        kif.rx = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        kif.rx = 1'b1;
        wait_idle();
        settle("glitch");

        send_frame(16'h0000, 1'b1, 1'b0);
        settle("key_release");
        do_ack();

        send_frame(16'h1234, 1'b0, even_par(16'h1234));
        settle("bad_stop");
        send_frame(16'hFFFF, 1'b1, even_par(16'hFFFF));
        settle("after_bad_stop");
        do_ack();
        settle("bad_stop_ack");

        // Reset part-way through the data bits drops the frame and all state.
        aaaa = 16'hAAAA;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(aaaa[i]);
        reset  = 1'b1;
        kif.rx = 1'b1;
        @(posedge clock);
        #1;
        reset   = 1'b0;
        m_out   = 16'h0000;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
        settle("mid_reset");
        send_frame(16'h5555, 1'b1, even_par(16'h5555));
        settle("after_reset");
        do_ack();

`ifdef HACK_KBD_RX_PARITY_EN
        send_frame(16'h0003, 1'b1, 1'b0);
        settle("parity_good");
        send_frame(16'h0003, 1'b1, 1'b1);
        settle("parity_bad");
        do_ack();
        settle("parity_ack");
`endif

        for (int k = 0; k < 24; k++) begin
            d    = 16'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            par  = even_par(d) ^ ($urandom_range(0, 4) == 0);
            send_frame(d, stop, par);
            settle($sformatf("rand%0d", k));
            if ($urandom_range(0, 1) == 1) do_ack();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/hack_kbd_rx.md
Name: hack_kbd_rx

Overview:
- Serial receiver that fills the Hack keyboard register (memory-mapped KBD word, address 24576).
- Accepts a UART-style frame on one line, LSB-first, and assembles a 16-bit key code.
- Presents the key code to the CPU/memory mux with a valid/ack handshake.
- Receive-side counterpart of the serial key-code transmitter in the keyboard model. The parallel word it produces feeds the same 16-bit datapath as the gate-level word units.

Parameters:
- CLKS_PER_BIT, 8: clock cycles per serial bit. Must be even and >= 4. Counter width is $clog2(CLKS_PER_BIT).
- SYNC_STAGES, 2: synchroniser flops on rx. Must be >= 2.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  serial line; idles high.
- ack  input  1  one-cycle pulse from the CPU side; consumes the current word.
- out  output  16  KBD register value (last good key code).
- valid  output  1  out holds an unconsumed word.
- busy  output  1  a frame is in progress (state != IDLE).
- frame_err  output  1  sticky; the last frame had a bad stop bit (or bad parity, see the optional feature).
- overrun  output  1  sticky; a new word overwrote an unacknowledged one.

Behaviour:
- Reset: out=0, valid=0, busy=0, frame_err=0, overrun=0, state=IDLE, counters=0. Synchroniser flops reset to 1.
- Reset asserted mid-frame aborts the frame. Nothing is committed, and the partial shift register is discarded.
- rx passes through SYNC_STAGES flops. All decisions below use the synchronised value rxs.
- Frame format: 1 start bit (0), 16 data bits LSB first, 1 stop bit (1).
- State machine:
  - IDLE: if rxs==0, go to START with cnt=0.
  - START: cnt counts up. At cnt==CLKS_PER_BIT/2-1:
    - if rxs==0, go to DATA with cnt=0, bitidx=0;
    - otherwise treat it as a glitch and return to IDLE with no flags set.
  - DATA: at cnt==CLKS_PER_BIT-1, sample rxs into shreg (shift right, new bit into bit 15), then bitidx++ and cnt=0. After bitidx 15 is sampled, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rxs and go to IDLE.
    - rxs==1 (commit): out<=shreg; valid<=1; overrun<=1 if valid was 1 and ack is not asserted this cycle.
    - rxs==0: frame_err<=1. out and valid are unchanged.
- Sampling point is mid-bit for every data and stop bit.
- Latency: the commit edge occurs SYNC_STAGES + CLKS_PER_BIT/2 + 17*CLKS_PER_BIT cycles (±1) after the first edge that samples rx==0 at the pin. out and valid change together on that edge.
- ack handling:
  - ack clears valid, overrun and frame_err on the next edge.
  - ack with valid==0 is harmless.
  - out is not cleared by ack. It holds the last key code, matching KBD semantics.
- Simultaneous ack and commit: the commit wins. valid stays 1, out takes the new word, overrun is not set, and any old frame_err is cleared.
- Simultaneous ack and stop-bit error: frame_err ends at 1.
- A key-release frame carrying 0x0000 commits normally: out=0, valid=1.
- busy is combinational from state (state != IDLE).
- rx held low forever: START→DATA→STOP with frame_err set, then IDLE. Because rxs is still 0, a new START begins immediately. No lockup.

Optional Feature:
- Macro: HACK_KBD_RX_PARITY_EN.
- With the macro defined:
  - The frame carries an even-parity bit between data bit 15 and the stop bit.
  - A PARITY state samples it at mid-bit.
  - Commit requires a good stop bit AND (^shreg ^ parity)==0. Otherwise frame_err<=1 and nothing commits.
  - Commit latency grows by CLKS_PER_BIT.
- Without the macro: there is no PARITY state, the frame is 18 bits, and frame_err reflects the stop bit only.

Test Plan:
- Reset, then rx idle high for 200 cycles → out=0x0000, valid=0, busy=0, no flags.
- CLKS_PER_BIT=8, send 0x0041 ('A') → valid rises 2+4+136 (±1) cycles after the start edge; out=0x0041. Pulse ack → valid=0 next cycle and out stays 0x0041.
- Send 0x0080 then 0x0084 without ack → out=0x0084, valid=1, overrun=1. One ack → valid=0, overrun=0.
- Drive start bit low for 3 cycles (less than 4) then high → glitch rejected: busy returns to 0, valid=0, frame_err=0.
- Send 0x1234 with stop bit 0 → frame_err=1 and out keeps its prior value. Then send 0xFFFF with a good stop bit → out=0xFFFF, valid=1. Ack clears both flags.
- Assert reset for 1 cycle midway through the data bits of 0xAAAA → all outputs 0. A following 0x5555 frame receives correctly.
- With HACK_KBD_RX_PARITY_EN defined: 0x0003 with parity 0 → commits. 0x0003 with parity 1 → frame_err=1, valid unchanged.
